// File: rtl/m68k_sram_arbiter.sv
// Round-robin CPU/DMA arbiter for an asynchronous 16-bit SRAM.
// Byte writes are done as read-modify-write so the SRAM only ever sees whole words.
module m68k_sram_arbiter #(
   parameter int ACCESS_CYCLES = 2
) (
   input  logic        clk_50mhz,
   input  logic        rst_n,
   input  logic        cpu_rd_ena,
   input  logic        cpu_wr_ena,
   input  logic [1:0]  cpu_byte_ena,
   input  logic [17:0] cpu_address,
   input  logic [15:0] cpu_wr_data,
   output logic [15:0] cpu_rd_data,
   output logic        cpu_data_ack,
   input  logic        dma_rd_ena,
   input  logic        dma_wr_ena,
   input  logic [17:0] dma_address,
   input  logic [15:0] dma_wr_data,
   output logic [15:0] dma_rd_data,
   output logic        dma_ack,
   output logic [17:0] sram_addr,
   inout  wire  [15:0] sram_data,
   output logic        sram_cs_n,
   output logic        sram_oe_n,
   output logic        sram_we_n
);

   typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_t;

   localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYCLES - 1);

   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic        last_dma, gnt_dma, op_rd;
   logic        grant_cpu, grant_dma;
   logic        cpu_req, dma_req, cnt_last, wr_drive;
   logic [15:0] wdata;
   logic [1:0]  ben;

   assign cpu_req  = cpu_rd_ena | cpu_wr_ena;
   assign dma_req  = dma_rd_ena | dma_wr_ena;
   assign cnt_last = (cnt == LAST_CNT);

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      grant_cpu = 1'b0;
      grant_dma = 1'b0;
      case (state)
         IDLE: begin
            cnt_d = 4'd0;
            // The cycle carrying an ack is skipped so a held request is not re-granted.
            if (!cpu_data_ack && !dma_ack) begin
               if (cpu_req && (!dma_req || last_dma)) grant_cpu = 1'b1;
               else if (dma_req)                      grant_dma = 1'b1;
            end
            if (grant_cpu) begin
               if (cpu_rd_ena)                state_d = RD;
               else if (cpu_byte_ena == 2'b11) state_d = WR_SETUP;
               else if (cpu_byte_ena == 2'b00) state_d = DONE;
               else                            state_d = RD;
            end else if (grant_dma) begin
               state_d = dma_rd_ena ? RD : WR_SETUP;
            end
         end
         RD: begin
            if (cnt_last) begin
               cnt_d   = 4'd0;
               state_d = op_rd ? DONE : WR_SETUP;
            end else begin
               cnt_d = cnt + 4'd1;
            end
         end
         WR_SETUP: begin
            cnt_d   = 4'd0;
            state_d = WR_PULSE;
         end
         WR_PULSE: begin
            if (cnt_last) state_d = WR_HOLD;
            else          cnt_d   = cnt + 4'd1;
         end
         WR_HOLD: state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_50mhz or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         last_dma     <= 1'b1;
         gnt_dma      <= 1'b0;
         op_rd        <= 1'b0;
         wdata        <= 16'd0;
         ben          <= 2'b00;
         sram_addr    <= 18'd0;
         cpu_rd_data  <= 16'd0;
         dma_rd_data  <= 16'd0;
         cpu_data_ack <= 1'b0;
         dma_ack      <= 1'b0;
      end else begin
         state        <= state_d;
         cnt          <= cnt_d;
         cpu_data_ack <= (state == DONE) && !gnt_dma;
         dma_ack      <= (state == DONE) && gnt_dma;
         if (grant_cpu) begin
            gnt_dma   <= 1'b0;
            last_dma  <= 1'b0;
            op_rd     <= cpu_rd_ena;
            sram_addr <= cpu_address;
            wdata     <= cpu_wr_data;
            ben       <= cpu_byte_ena;
         end else if (grant_dma) begin
            gnt_dma   <= 1'b1;
            last_dma  <= 1'b1;
            op_rd     <= dma_rd_ena;
            sram_addr <= dma_address;
            wdata     <= dma_wr_data;
            ben       <= 2'b11;
         end
         if (state == RD && cnt_last) begin
            if (op_rd) begin
               if (gnt_dma) dma_rd_data <= sram_data;
               else         cpu_rd_data <= sram_data;
            end else begin
               // Read half of a byte write: keep the untouched lane from the SRAM.
               wdata <= {ben[1] ? wdata[15:8] : sram_data[15:8],
                         ben[0] ? wdata[7:0]  : sram_data[7:0]};
            end
         end
      end
   end

   // Strobes decode straight from the state register so reset releases them at once.
   assign wr_drive  = (state == WR_SETUP) || (state == WR_PULSE) || (state == WR_HOLD);
   assign sram_cs_n = (state == IDLE) || (state == DONE);
   assign sram_oe_n = (state != RD);
   assign sram_we_n = (state != WR_PULSE);
   assign sram_data = wr_drive ? wdata : 16'bz;

endmodule

// File: tb/tb_m68k_sram_arbiter.sv
// Bench for m68k_sram_arbiter: SRAM model, directed table, multi-cycle sequences
// and randomized transactions scored against a transaction-level model.
module tb_m68k_sram_arbiter;
   localparam int AC = 2;

   logic        clk_50mhz = 1'b0;
   logic        rst_n = 1'b0;
   logic        cpu_rd_ena = 1'b0, cpu_wr_ena = 1'b0;
   logic [1:0]  cpu_byte_ena = 2'b00;
   logic [17:0] cpu_address = '0;
   logic [15:0] cpu_wr_data = '0;
   logic [15:0] cpu_rd_data;
   logic        cpu_data_ack;
   logic        dma_rd_ena = 1'b0, dma_wr_ena = 1'b0;
   logic [17:0] dma_address = '0;
   logic [15:0] dma_wr_data = '0;
   logic [15:0] dma_rd_data;
   logic        dma_ack;
   logic [17:0] sram_addr;
   wire  [15:0] sram_data;
   logic        sram_cs_n, sram_oe_n, sram_we_n;

   m68k_sram_arbiter #(.ACCESS_CYCLES(AC)) dut (
      .clk_50mhz(clk_50mhz), .rst_n(rst_n),
      .cpu_rd_ena(cpu_rd_ena), .cpu_wr_ena(cpu_wr_ena), .cpu_byte_ena(cpu_byte_ena),
      .cpu_address(cpu_address), .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data),
      .cpu_data_ack(cpu_data_ack),
      .dma_rd_ena(dma_rd_ena), .dma_wr_ena(dma_wr_ena), .dma_address(dma_address),
      .dma_wr_data(dma_wr_data), .dma_rd_data(dma_rd_data), .dma_ack(dma_ack),
      .sram_addr(sram_addr), .sram_data(sram_data),
      .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n));

   always #10 clk_50mhz = ~clk_50mhz;

   logic [15:0] mem     [0:1023];
   logic [15:0] ref_mem [0:1023];
   assign sram_data = (!sram_cs_n && !sram_oe_n && sram_we_n) ? mem[sram_addr[9:0]] : 16'bz;

   int checks = 0, errors = 0;
   int oe_cyc = 0, cs_cyc = 0, we_pulses = 0;
   logic we_prev = 1'b1;
   bit m_last_dma = 1'b1;
   logic [15:0] m_cpu_rd = '0, m_dma_rd = '0;

   typedef struct {
      bit c_rd; bit c_wr; logic [1:0] c_be; logic [17:0] c_a; logic [15:0] c_d;
      bit d_rd; bit d_wr; logic [17:0] d_a; logic [15:0] d_d;
      int e_lat; logic [15:0] e_rd; int e_oe; int e_we; int e_cs;
      logic [17:0] m_a; logic [15:0] m_d;
   } vec_t;
   vec_t vecs [8];

   function automatic logic [15:0] pre(int i);
      return 16'(i * 3 + 'h1000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: bus checks and SRAM write capture mid-cycle, then step past the edge.
   task automatic tick();
      @(negedge clk_50mhz);
      chk("oe_we_overlap", {31'd0, !sram_oe_n && !sram_we_n}, 32'd0);
      if (!sram_oe_n) chk("read_bus", {16'd0, sram_data}, {16'd0, mem[sram_addr[9:0]]});
      if (!sram_cs_n && !sram_we_n) mem[sram_addr[9:0]] = sram_data;
      if (!sram_oe_n) oe_cyc++;
      if (!sram_cs_n) cs_cyc++;
      if (!sram_we_n && we_prev) we_pulses++;
      we_prev = sram_we_n;
      @(posedge clk_50mhz);
      #1;
   endtask

   function automatic int lat(bit rd, bit is_dma, logic [1:0] be);
      if (rd)                    return AC + 2;
      if (is_dma || be == 2'b11) return AC + 4;
      if (be == 2'b00)           return 2;
      return 2 * AC + 4;
   endfunction

   // Transaction model: grant order from the round-robin rule, effects on memory and rd_data.
   task automatic model(input vec_t v, output int elc, output int eld);
      bit c_on, d_on, cpu_first;
      logic [15:0] old;
      c_on = v.c_rd | v.c_wr;
      d_on = v.d_rd | v.d_wr;
      cpu_first = c_on && (!d_on || m_last_dma);
      elc = -1;
      eld = -1;
      for (int k = 0; k < 2; k++) begin
         if ((k == 0) == cpu_first) begin
            if (c_on) begin
               elc = (k == 0) ? lat(v.c_rd, 1'b0, v.c_be) : eld + 1 + lat(v.c_rd, 1'b0, v.c_be);
               old = ref_mem[v.c_a[9:0]];
               if (v.c_rd) m_cpu_rd = old;
               else ref_mem[v.c_a[9:0]] = {v.c_be[1] ? v.c_d[15:8] : old[15:8],
                                           v.c_be[0] ? v.c_d[7:0]  : old[7:0]};
               m_last_dma = 1'b0;
            end
         end else if (d_on) begin
            eld = (k == 0) ? lat(v.d_rd, 1'b1, 2'b11) : elc + 1 + lat(v.d_rd, 1'b1, 2'b11);
            if (v.d_rd) m_dma_rd = ref_mem[v.d_a[9:0]];
            else        ref_mem[v.d_a[9:0]] = v.d_d;
            m_last_dma = 1'b1;
         end
      end
   endtask

   task automatic run(input vec_t v, output int lc, output int ld, output logic [15:0] rc,
                      output logic [15:0] rdd, output int n_oe, output int n_we, output int n_cs);
      bit cdone, ddone;
      int s_oe, s_we, s_cs;
      s_oe = oe_cyc; s_we = we_pulses; s_cs = cs_cyc;
      lc = -1; ld = -1; rc = '0; rdd = '0;
      cdone = !(v.c_rd | v.c_wr);
      ddone = !(v.d_rd | v.d_wr);
      cpu_rd_ena = v.c_rd; cpu_wr_ena = v.c_wr; cpu_byte_ena = v.c_be;
      cpu_address = v.c_a; cpu_wr_data = v.c_d;
      dma_rd_ena = v.d_rd; dma_wr_ena = v.d_wr; dma_address = v.d_a; dma_wr_data = v.d_d;
      for (int t = 1; t <= 200 && !(cdone && ddone); t++) begin
         tick();
         chk("dual_ack", {31'd0, cpu_data_ack & dma_ack}, 32'd0);
         if (cpu_data_ack && !cdone) begin
            lc = t; rc = cpu_rd_data; cdone = 1'b1;
            cpu_rd_ena = 1'b0; cpu_wr_ena = 1'b0;
         end
         if (dma_ack && !ddone) begin
            ld = t; rdd = dma_rd_data; ddone = 1'b1;
            dma_rd_ena = 1'b0; dma_wr_ena = 1'b0;
         end
      end
      chk("ack_timeout", {30'd0, cdone, ddone}, 32'd3);
      n_oe = oe_cyc - s_oe; n_we = we_pulses - s_we; n_cs = cs_cyc - s_cs;
      tick();
   endtask

   initial begin
      int lc, ld, n_oe, n_we, n_cs, elc, eld, n, mism;
      logic [15:0] rc, rdd;
      logic [3:0] order;
      vec_t v;

      for (int i = 0; i < 1024; i++) begin
         mem[i] = pre(i);
         ref_mem[i] = pre(i);
      end
      mem[16'h10] = 16'hBEEF; ref_mem[16'h10] = 16'hBEEF;
      mem[16'h20] = 16'h1234; ref_mem[16'h20] = 16'h1234;

      // Reset state
      #5;
      chk("rst_cs_n", {31'd0, sram_cs_n}, 32'd1);
      chk("rst_oe_we", {30'd0, sram_oe_n, sram_we_n}, 32'd3);
      chk("rst_acks", {30'd0, cpu_data_ack, dma_ack}, 32'd0);
      chk("rst_rd_data", {cpu_rd_data, dma_rd_data}, 32'd0);
      chk("rst_addr", {14'd0, sram_addr}, 32'd0);
      @(negedge clk_50mhz);
      rst_n = 1'b1;
      @(posedge clk_50mhz);
      #1;

      // Held CPU read vs DMA write from reset: grants must alternate, CPU first
      cpu_rd_ena = 1'b1; cpu_address = 18'h10;
      dma_wr_ena = 1'b1; dma_address = 18'h40; dma_wr_data = 16'h7777;
      n = 0; order = '0;
      for (int c = 0; c < 100 && n < 4; c++) begin
         tick();
         chk("alt_dual_ack", {31'd0, cpu_data_ack & dma_ack}, 32'd0);
         if (cpu_data_ack && n < 4) begin order[n] = 1'b0; n++; end
         if (dma_ack && n < 4)      begin order[n] = 1'b1; n++; end
         if (n == 4) begin cpu_rd_ena = 1'b0; dma_wr_ena = 1'b0; end
      end
      chk("alt_count", n, 4);
      chk("alt_order", {28'd0, order}, 32'b1010);
      chk("alt_cpu_rd", {16'd0, cpu_rd_data}, 32'hBEEF);
      tick();
      chk("alt_mem", {16'd0, mem[16'h40]}, 32'h7777);
      ref_mem[16'h40] = 16'h7777; m_last_dma = 1'b1; m_cpu_rd = 16'hBEEF;

      // Directed table: single requester, fixed expectations
      vecs[0] = '{1,0,2'b00,18'h10,16'h0000, 0,0,18'h0,16'h0,    4,16'hBEEF,2,0,2, 18'h10,16'hBEEF};
      vecs[1] = '{0,1,2'b10,18'h20,16'hAB00, 0,0,18'h0,16'h0,    8,16'hBEEF,2,1,6, 18'h20,16'hAB34};
      vecs[2] = '{0,1,2'b00,18'h30,16'hFFFF, 0,0,18'h0,16'h0,    2,16'hBEEF,0,0,0, 18'h30,16'h1090};
      vecs[3] = '{0,1,2'b11,18'h31,16'h5A5A, 0,0,18'h0,16'h0,    6,16'hBEEF,0,1,4, 18'h31,16'h5A5A};
      vecs[4] = '{0,0,2'b00,18'h0,16'h0,     1,0,18'h31,16'h0,   4,16'h5A5A,2,0,2, 18'h31,16'h5A5A};
      vecs[5] = '{0,1,2'b01,18'h20,16'h00C3, 0,0,18'h0,16'h0,    8,16'hBEEF,2,1,6, 18'h20,16'hABC3};
      vecs[6] = '{0,0,2'b00,18'h0,16'h0,     0,1,18'h32,16'h1111,6,16'h5A5A,0,1,4, 18'h32,16'h1111};
      vecs[7] = '{1,1,2'b11,18'h32,16'hFFFF, 0,0,18'h0,16'h0,    4,16'h1111,2,0,2, 18'h32,16'h1111};
      for (int i = 0; i < 8; i++) begin
         model(vecs[i], elc, eld);
         run(vecs[i], lc, ld, rc, rdd, n_oe, n_we, n_cs);
         if (vecs[i].c_rd | vecs[i].c_wr) begin
            chk($sformatf("tbl%0d_lat", i), lc, vecs[i].e_lat);
            chk($sformatf("tbl%0d_rd", i), {16'd0, rc}, {16'd0, vecs[i].e_rd});
         end else begin
            chk($sformatf("tbl%0d_lat", i), ld, vecs[i].e_lat);
            chk($sformatf("tbl%0d_rd", i), {16'd0, rdd}, {16'd0, vecs[i].e_rd});
         end
         chk($sformatf("tbl%0d_oe", i), n_oe, vecs[i].e_oe);
         chk($sformatf("tbl%0d_we", i), n_we, vecs[i].e_we);
         chk($sformatf("tbl%0d_cs", i), n_cs, vecs[i].e_cs);
         chk($sformatf("tbl%0d_mem", i), {16'd0, mem[vecs[i].m_a[9:0]]}, {16'd0, vecs[i].m_d});
      end

      // Reset in the middle of a write pulse
      cpu_wr_ena = 1'b1; cpu_byte_ena = 2'b11; cpu_address = 18'h50; cpu_wr_data = 16'hDEAD;
      for (int c = 0; c < 20 && sram_we_n; c++) tick();
      chk("mid_pulse_reached", {31'd0, sram_we_n}, 32'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_we", {31'd0, sram_we_n}, 32'd1);
      chk("mid_rst_cs_oe", {30'd0, sram_cs_n, sram_oe_n}, 32'd3);
      chk("mid_rst_rd_data", {16'd0, cpu_rd_data}, 32'd0);
      chk("mid_rst_addr", {14'd0, sram_addr}, 32'd0);
      cpu_wr_ena = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("mid_rst_no_ack", {30'd0, cpu_data_ack, dma_ack}, 32'd0);
      end
      rst_n = 1'b1;
      m_last_dma = 1'b1; m_cpu_rd = '0; m_dma_rd = '0;
      v = '{1,0,2'b00,18'h50,16'h0, 0,0,18'h0,16'h0, 0,16'h0,0,0,0, 18'h0,16'h0};
      model(v, elc, eld);
      run(v, lc, ld, rc, rdd, n_oe, n_we, n_cs);
      chk("post_rst_lat", lc, elc);
      chk("post_rst_rd", {16'd0, rc}, {16'd0, m_cpu_rd});

      // Randomized transactions, possibly contending, against the model
      for (int i = 0; i < 40; i++) begin
         int sel;
         sel = $urandom_range(0, 2);
         v = '{0,0,2'b00,18'h0,16'h0, 0,0,18'h0,16'h0, 0,16'h0,0,0,0, 18'h0,16'h0};
         if (sel != 1) begin
            v.c_rd = 1'($urandom_range(0, 1));
            v.c_wr = v.c_rd ? 1'($urandom_range(0, 1)) : 1'b1;
            v.c_be = 2'($urandom_range(0, 3));
            v.c_a  = 18'($urandom_range(0, 63));
            v.c_d  = 16'($urandom);
         end
         if (sel != 0) begin
            v.d_rd = 1'($urandom_range(0, 1));
            v.d_wr = v.d_rd ? 1'($urandom_range(0, 1)) : 1'b1;
            v.d_a  = 18'($urandom_range(0, 63));
            v.d_d  = 16'($urandom);
         end
         model(v, elc, eld);
         run(v, lc, ld, rc, rdd, n_oe, n_we, n_cs);
         if (sel != 1) begin
            chk($sformatf("rnd%0d_cpu_lat", i), lc, elc);
            chk($sformatf("rnd%0d_cpu_rd", i), {16'd0, rc}, {16'd0, m_cpu_rd});
         end
         if (sel != 0) begin
            chk($sformatf("rnd%0d_dma_lat", i), ld, eld);
            chk($sformatf("rnd%0d_dma_rd", i), {16'd0, rdd}, {16'd0, m_dma_rd});
         end
      end
      mism = 0;
      for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
      chk("final_mem_mismatches", mism, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/m68k_sram_arbiter.md
M68K_SRAM_ARBITER -- requirements
Module: m68k_sram_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, default 2, number of cycles OE_n or WE_n is held low per SRAM access; legal range 1..15.
REQ-002 clk_50mhz  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cpu_rd_ena  input  1  CPU read request; held until cpu_data_ack.
REQ-005 cpu_wr_ena  input  1  CPU write request; held until cpu_data_ack.
REQ-006 cpu_byte_ena  input  2  byte lanes; [1] = data[15:8] (even byte), [0] = data[7:0].
REQ-007 cpu_address  input  18  CPU word address into SRAM.
REQ-008 cpu_wr_data  input  16  CPU write data.
REQ-009 cpu_rd_data  output  16  CPU read data; valid in the cpu_data_ack cycle.
REQ-010 cpu_data_ack  output  1  one-cycle completion pulse to CPU.
REQ-011 dma_rd_ena / dma_wr_ena  input  1 each  DMA (UART loader) word read/write requests; held until dma_ack.
REQ-012 dma_address  input  18  DMA word address; dma_wr_data input 16; dma_rd_data output 16.
REQ-013 dma_ack  output  1  one-cycle completion pulse to DMA.
REQ-014 sram_addr  output  18; sram_data  inout  16; sram_cs_n, sram_oe_n, sram_we_n  output  1  active-low SRAM strobes.

Function
REQ-015 States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-016 Requests are sampled only in IDLE; address, write data, byte enables and requester are latched in the grant cycle.
REQ-017 Arbitration is round-robin: on simultaneous requests, the requester not granted last wins; the last-granted pointer resets to DMA, so the CPU wins the first tie.
REQ-018 A single pending requester is granted immediately in IDLE, regardless of the pointer.
REQ-019 rd_ena and wr_ena both high is treated as a read; no SRAM write occurs.
REQ-020 Read: IDLE -> RD for ACCESS_CYCLES cycles (cs_n=0, oe_n=0); sram_data is registered at the last RD cycle; then DONE.
REQ-021 Word write (byte_ena=11, or any DMA write): IDLE -> WR_SETUP for 1 cycle (cs_n=0, we_n=1, data driven) -> WR_PULSE for ACCESS_CYCLES cycles (we_n=0) -> WR_HOLD for 1 cycle (we_n=1, data driven) -> DONE.
REQ-022 Byte write (byte_ena 01 or 10): read-modify-write as RD, then merge, then WR_SETUP/WR_PULSE/WR_HOLD, then DONE.
REQ-023 Merge rule: upper byte = byte_ena[1] ? wr_data[15:8] : read[15:8]; lower byte = byte_ena[0] ? wr_data[7:0] : read[7:0].
REQ-024 A CPU write with byte_ena=00 performs no SRAM cycle: IDLE -> DONE, then ack.
REQ-025 DONE: assert the granted requester's ack for exactly 1 cycle, return to IDLE, and sample new requests the following cycle.
REQ-026 Latency from request to ack in cycles: read = ACCESS_CYCLES+2; word write = ACCESS_CYCLES+4; byte write = 2*ACCESS_CYCLES+4.
REQ-027 sram_data is driven only in WR_SETUP, WR_PULSE and WR_HOLD; otherwise it is high-Z.
REQ-028 oe_n and we_n are never both low; oe_n=1 in every write state.
REQ-029 cs_n=1 and oe_n=we_n=1 in IDLE and DONE.
REQ-030 sram_addr holds the latched address from the grant cycle until DONE.
REQ-031 cpu_rd_data and dma_rd_data hold their last value until the next read completes for that requester.
REQ-032 The ungranted requester sees no ack and waits with its request held; starvation is bounded to one transaction.

Reset
REQ-033 While rst_n=0, all of the following hold asynchronously: state=IDLE; cs_n=oe_n=we_n=1; sram_data high-Z; acks=0; rd_data=0; sram_addr=0; pointer=DMA.
REQ-034 Reset mid-transaction aborts it with no ack, including mid-WR_PULSE, where we_n rises immediately.

Verification
REQ-035 ACCESS_CYCLES=2, CPU read of addr 0x00010 preloaded 0xBEEF -> oe_n low for 2 cycles; cpu_data_ack on cycle 4 after request; cpu_rd_data=0xBEEF.
REQ-036 SRAM word 0x1234, CPU write 0xAB00 with byte_ena=10 -> one read, then one 2-cycle we_n pulse writing 0xAB34; ack on cycle 8.
REQ-037 cpu_rd_ena and dma_wr_ena asserted together from reset, held continuously -> grants alternate CPU, DMA, CPU, DMA; never two acks in the same cycle.
REQ-038 CPU write with byte_ena=00 -> cs_n stays high; ack 2 cycles after request; SRAM unchanged.
REQ-039 rst_n pulled low during WR_PULSE -> we_n=1 and sram_data=Z within the same cycle; no ack; next request after release completes normally.
REQ-040 Every cycle, checker asserts !(oe_n==0 && we_n==0) and that sram_data is not driven while oe_n=0.
